// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha20 entropy front-end.
package chacha_pkg;

  localparam int unsigned TRNG_WORD_W      = 32;
  localparam int unsigned TRNG_KEY_WORDS   = 8;
  localparam int unsigned TRNG_NONCE_WORDS = 3;
  localparam int unsigned TRNG_CTR_WORDS   = 1;

  typedef enum logic [1:0] {
    WARMUP,
    RUN,
    FAIL
  } trng_buf_state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// Synchronous show-ahead word FIFO with flush; pointers wrap modulo DEPTH.
module trng_word_fifo
  import chacha_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [TRNG_WORD_W-1:0]   wdata,
  output logic [TRNG_WORD_W-1:0]   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [TRNG_WORD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q;
  logic [PtrW-1:0]        rd_ptr_q;
  logic [PtrW:0]          count_q;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so a push into a full FIFO in the same cycle lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/trng_chunk_buffer.sv
// Entropy bit packer with repetition-count health test, warmup discard and
// a request/ready word server feeding the ChaCha20 core.
module trng_chunk_buffer
  import chacha_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned REP_LIMIT    = 32,
  parameter int unsigned WARMUP_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   raw_bit,
  input  logic                   raw_valid,
  input  logic                   trng_request,
  output logic                   trng_ready,
  output logic [TRNG_WORD_W-1:0] trng_data,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   health_fail,
  input  logic                   clear_fail
);

  trng_buf_state_t        state_q, state_d;
  logic [TRNG_WORD_W-1:0] shreg_q, shreg_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             run_cnt_q, run_cnt_d;
  logic                   prev_bit_q, prev_bit_d;
  logic [7:0]             warm_cnt_q, warm_cnt_d;
  logic                   fail_q, fail_d;
  logic                   ready_q, ready_d;
  logic [TRNG_WORD_W-1:0] data_q, data_d;

  logic                   accept;
  logic [7:0]             run_next;
  logic                   rep_hit;
  logic                   word_done;
  logic [TRNG_WORD_W-1:0] word;
  logic                   push;
  logic                   pop_go;
  logic [TRNG_WORD_W-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  assign accept    = raw_valid & enable & (state_q != FAIL);
  // A zero run count means no previous bit since reset or the last failure.
  assign run_next  = ((run_cnt_q != 8'd0) && (raw_bit == prev_bit_q)) ? run_cnt_q + 8'd1 : 8'd1;
  assign rep_hit   = accept & ({24'b0, run_next} >= REP_LIMIT);
  assign word_done = accept & (bit_cnt_q == 5'd31) & ~rep_hit;
  assign word      = {shreg_q[TRNG_WORD_W-2:0], raw_bit};
  assign push      = word_done & (state_q == RUN) & (~fifo_full | pop_go);
  assign pop_go    = trng_request & ~fifo_empty & (state_q == RUN) & ~ready_q & ~rep_hit;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    run_cnt_d  = run_cnt_q;
    prev_bit_d = prev_bit_q;
    warm_cnt_d = warm_cnt_q;
    fail_d     = fail_q;
    ready_d    = pop_go;
    data_d     = pop_go ? fifo_rdata : data_q;

    if (accept) begin
      shreg_d    = word;
      bit_cnt_d  = bit_cnt_q + 5'd1;
      prev_bit_d = raw_bit;
      run_cnt_d  = run_next;
    end

    unique case (state_q)
      WARMUP: begin
        if (word_done) begin
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (({24'b0, warm_cnt_q} + 32'd1) >= WARMUP_WORDS) state_d = RUN;
        end
      end
      RUN: begin
      end
      FAIL: begin
        if (clear_fail) begin
          state_d    = WARMUP;
          fail_d     = 1'b0;
          bit_cnt_d  = 5'd0;
          warm_cnt_d = 8'd0;
        end
      end
      default: state_d = WARMUP;
    endcase

    if (rep_hit) begin
      state_d   = FAIL;
      fail_d    = 1'b1;
      bit_cnt_d = 5'd0;
      run_cnt_d = 8'd0;
      shreg_d   = '0;
      data_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WARMUP;
      shreg_q    <= '0;
      bit_cnt_q  <= 5'd0;
      run_cnt_q  <= 8'd0;
      prev_bit_q <= 1'b0;
      warm_cnt_q <= 8'd0;
      fail_q     <= 1'b0;
      ready_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      run_cnt_q  <= run_cnt_d;
      prev_bit_q <= prev_bit_d;
      warm_cnt_q <= warm_cnt_d;
      fail_q     <= fail_d;
      ready_q    <= ready_d;
      data_q     <= data_d;
    end
  end

  trng_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rep_hit),
    .push  (push),
    .pop   (pop_go),
    .wdata (word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign trng_ready  = ready_q;
  assign trng_data   = data_q;
  assign fill_level  = fifo_count;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_chunk_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based behavioural model of the entropy buffer.
module tb_trng_chunk_buffer;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned REP_LIMIT    = 32;
  localparam int unsigned WARMUP_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        trng_request = 1'b0;
  logic        clear_fail = 1'b0;
  logic        trng_ready;
  logic [31:0] trng_data;
  logic [4:0]  fill_level;
  logic        health_fail;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  trng_chunk_buffer #(
    .DEPTH        (DEPTH),
    .REP_LIMIT    (REP_LIMIT),
    .WARMUP_WORDS (WARMUP_WORDS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .raw_bit      (raw_bit),
    .raw_valid    (raw_valid),
    .trng_request (trng_request),
    .trng_ready   (trng_ready),
    .trng_data    (trng_data),
    .fill_level   (fill_level),
    .health_fail  (health_fail),
    .clear_fail   (clear_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_warm;
  bit          m_failed;
  int          m_warm_words;
  int          m_bits;
  int          m_run;
  logic        m_prev;
  logic [31:0] m_word;
  logic [31:0] m_q[$];
  logic        exp_ready;
  logic [31:0] exp_data;
  logic        exp_fail;

  task automatic model_reset();
    m_warm = 1'b1; m_failed = 1'b0; m_warm_words = 0; m_bits = 0; m_run = 0;
    m_prev = 1'b0; m_word = '0; m_q.delete();
    exp_ready = 1'b0; exp_data = '0; exp_fail = 1'b0;
  endtask

  task automatic model_step();
    bit acc, pop, done;
    acc  = raw_valid && enable && !m_failed;
    pop  = trng_request && (m_q.size() > 0) && !m_warm && !m_failed && !exp_ready;
    done = 1'b0;
    if (m_failed) begin
      exp_ready = 1'b0;
      if (clear_fail) begin
        m_failed = 1'b0; m_warm = 1'b1; m_warm_words = 0; m_bits = 0; exp_fail = 1'b0;
      end
      return;
    end
    if (acc) begin
      m_run  = (m_run > 0 && raw_bit == m_prev) ? m_run + 1 : 1;
      m_prev = raw_bit;
      if (m_run >= int'(REP_LIMIT)) begin
        m_failed = 1'b1; exp_fail = 1'b1; m_q.delete(); m_bits = 0; m_run = 0;
        exp_data = '0; exp_ready = 1'b0;
        return;
      end
      m_word = {m_word[30:0], raw_bit};
      m_bits++;
      if (m_bits == 32) begin
        done = 1'b1; m_bits = 0;
      end
    end
    if (pop) exp_data = m_q.pop_front();
    exp_ready = pop;
    if (done) begin
      if (m_warm) begin
        m_warm_words++;
        if (m_warm_words >= int'(WARMUP_WORDS)) m_warm = 1'b0;
      end else if (m_q.size() < int'(DEPTH)) begin
        m_q.push_back(m_word);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] pulse_data[$];
  int          pulse_cyc[$];
  int          pulse_fill[$];

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("ready", 64'(trng_ready), 64'(exp_ready));
      check("data", 64'(trng_data), 64'(exp_data));
      check("fill_level", 64'(fill_level), 64'(m_q.size()));
      check("health_fail", 64'(health_fail), 64'(exp_fail));
      if (trng_ready) begin
        pulse_data.push_back(trng_data);
        pulse_cyc.push_back(cyc);
        pulse_fill.push_back(int'(fill_level));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int last_edge = 0;

  task automatic send_bit(input logic b);
    @(negedge clk);
    enable = 1'b1; raw_valid = 1'b1; raw_bit = b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    last_edge = cyc + 1;
    @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      raw_valid = 1'b0;
    end
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (pulse_data.size() < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (pulse_data.size() < target) check({name, "_timeout"}, 64'(pulse_data.size()), 64'(target));
  endtask

  task automatic warmup();
    for (int i = 0; i < int'(WARMUP_WORDS); i++) send_word($urandom | 32'h1);
  endtask

  task automatic pulse_reset_release();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          b;
  logic [31:0] words[12];
  logic [31:0] x;
  bit          stuck;

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_ready", 64'(trng_ready), 64'd0);
    check("rst_data", 64'(trng_data), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_health", 64'(health_fail), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Two known words, then a held request drains them.
    warmup();
    check("warm_fill", 64'(fill_level), 64'd0);
    send_word(32'hDEADBEEF);
    send_word(32'h01234567);
    check("two_fill", 64'(fill_level), 64'd2);
    b = pulse_data.size();
    trng_request = 1'b1;
    wait_pulses(b + 2, 20, "two");
    trng_request = 1'b0;
    idle(5);
    check("two_count", 64'(pulse_data.size() - b), 64'd2);
    if (pulse_data.size() >= b + 2) begin
      check("two_w0", 64'(pulse_data[b]), 64'hDEADBEEF);
      check("two_w1", 64'(pulse_data[b+1]), 64'h01234567);
      check("two_gap", 64'(pulse_cyc[b+1] - pulse_cyc[b] >= 2), 64'd1);
      check("two_fill0", 64'(pulse_fill[b]), 64'd1);
      check("two_fill1", 64'(pulse_fill[b+1]), 64'd0);
    end

    // Overfill: 17 words, the last one is dropped.
    for (int i = 0; i < 17; i++) send_word(32'h1000_0000 + i);
    check("full_fill", 64'(fill_level), 64'd16);
    check("model_full", 64'(m_q.size()), 64'd16);
    b = pulse_data.size();
    trng_request = 1'b1;
    wait_pulses(b + 16, 100, "drain");
    trng_request = 1'b0;
    idle(5);
    check("drain_count", 64'(pulse_data.size() - b), 64'd16);
    for (int i = 0; i < 16; i++)
      if (b + i < pulse_data.size()) check("drain_word", 64'(pulse_data[b+i]), 64'(32'h1000_0000 + i));
    check("drain_fill", 64'(fill_level), 64'd0);

    // Health failure with three words stored.
    for (int i = 0; i < 3; i++) send_word($urandom | 32'h1);
    check("pre_fail_fill", 64'(fill_level), 64'd3);
    for (int i = 0; i < 32; i++) send_bit(1'b0);
    @(negedge clk);
    raw_valid = 1'b0;
    #1;
    check("fail_flag", 64'(health_fail), 64'd1);
    check("fail_fill", 64'(fill_level), 64'd0);
    check("model_fail", 64'(exp_fail), 64'd1);
    b = pulse_data.size();
    trng_request = 1'b1;
    send_word($urandom);
    idle(10);
    check("fail_no_pulse", 64'(pulse_data.size() - b), 64'd0);
    trng_request = 1'b0;
    @(negedge clk); clear_fail = 1'b1;
    @(negedge clk); clear_fail = 1'b0;
    #1;
    check("cleared", 64'(health_fail), 64'd0);
    trng_request = 1'b1;
    warmup();
    check("post_clear_none", 64'(pulse_data.size() - b), 64'd0);
    x = $urandom | 32'h1;
    send_word(x);
    wait_pulses(b + 1, 10, "post_clear");
    idle(3);
    check("post_clear_count", 64'(pulse_data.size() - b), 64'd1);
    if (pulse_data.size() > b) check("post_clear_word", 64'(pulse_data[b]), 64'(x));

    // Empty FIFO with request high: pulse exactly one edge after completion.
    b = pulse_data.size();
    idle(5);
    check("empty_no_pulse", 64'(pulse_data.size() - b), 64'd0);
    send_word(32'hCAFEF00D);
    wait_pulses(b + 1, 10, "cafe");
    trng_request = 1'b0;
    if (pulse_data.size() > b) begin
      check("cafe_word", 64'(pulse_data[b]), 64'hCAFEF00D);
      check("cafe_latency", 64'(pulse_cyc[b]), 64'(last_edge + 1));
    end

    // Core emulation: 12 words, request dropped in every ready cycle.
    for (int i = 0; i < 12; i++) begin
      words[i] = $urandom | 32'h1;
      send_word(words[i]);
    end
    check("core_fill", 64'(fill_level), 64'd12);
    b = pulse_data.size();
    for (int k = 0; k < 200 && pulse_data.size() < b + 12; k++) begin
      @(negedge clk); #1;
      trng_request = !trng_ready;
    end
    trng_request = 1'b0;
    idle(4);
    check("core_count", 64'(pulse_data.size() - b), 64'd12);
    for (int i = 0; i < 12; i++)
      if (b + i < pulse_data.size()) check("core_word", 64'(pulse_data[b+i]), 64'(words[i]));
    check("core_fill0", 64'(fill_level), 64'd0);

    // Reset during a ready pulse.
    send_word($urandom | 32'h1);
    trng_request = 1'b1;
    for (int k = 0; k < 10 && !trng_ready; k++) begin
      @(negedge clk); #1;
    end
    check("pulse_seen", 64'(trng_ready), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rstp_ready", 64'(trng_ready), 64'd0);
    check("rstp_data", 64'(trng_data), 64'd0);
    check("rstp_fill", 64'(fill_level), 64'd0);
    trng_request = 1'b0;
    pulse_reset_release();

    // Reset mid-word at bit 17, then a full warmup is needed again.
    warmup();
    for (int i = 0; i < 17; i++) send_bit(1'($urandom));
    raw_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstw_ready", 64'(trng_ready), 64'd0);
    check("rstw_data", 64'(trng_data), 64'd0);
    check("rstw_fill", 64'(fill_level), 64'd0);
    check("rstw_health", 64'(health_fail), 64'd0);
    pulse_reset_release();
    warmup();
    check("rewarm_fill", 64'(fill_level), 64'd0);
    x = $urandom | 32'h1;
    send_word(x);
    check("rewarm_push", 64'(fill_level), 64'd1);
    b = pulse_data.size();
    trng_request = 1'b1;
    wait_pulses(b + 1, 10, "rewarm");
    trng_request = 1'b0;
    if (pulse_data.size() > b) check("rewarm_word", 64'(pulse_data[b]), 64'(x));

    // Randomized traffic with occasional stuck-bit bursts.
    stuck = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) stuck = !stuck;
      raw_valid    = ($urandom_range(0, 3) != 0);
      enable       = ($urandom_range(0, 15) != 0);
      raw_bit      = stuck ? raw_bit : 1'($urandom_range(0, 1));
      trng_request = ($urandom_range(0, 2) != 0);
      clear_fail   = ($urandom_range(0, 39) == 0);
    end
    raw_valid = 1'b0; trng_request = 1'b0; clear_fail = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
